// File: rtl/seq_detector.sv
// Serial pattern detector fed by a single-bit flop stream; pulses match and counts hits.
// Overlapping detection is enabled by defining SEQ_DET_OVERLAP_EN.
module seq_detector #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1011),
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             sat,
  output logic [PAT_W-1:0] hist,
  output logic             armed
);

  localparam int unsigned      FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_e;

  state_e            state_q;
  logic [FILL_W-1:0] fill_q;
  logic [PAT_W-1:0]  hist_q;
  logic [PAT_W-1:0]  hist_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              match_q;
  logic              sat_q;
  logic              full_c;
  logic              hit_c;

  // Shifted history and hit decision for the current edge
  always_comb begin
    hist_d = {hist_q[PAT_W-2:0], din};
    full_c = (state_q == ARMED) || (fill_q == FILL_LAST);
    hit_c  = din_vld && full_c && (hist_d == PATTERN);
    cnt_d  = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      fill_q  <= '0;
      hist_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (din_vld) begin
        hist_q <= hist_d;
        case (state_q)
          FILL: begin
            if (fill_q == FILL_LAST) begin
              state_q <= ARMED;
              fill_q  <= '0;
            end else begin
              fill_q <= fill_q + FILL_W'(1);
            end
          end
          ARMED:   state_q <= ARMED;
          default: state_q <= FILL;
        endcase
        if (hit_c) begin
          match_q <= 1'b1;
`ifdef SEQ_DET_OVERLAP_EN
          state_q <= ARMED;
`else
          // Non-overlapping: the next hit must be built from fresh bits
          hist_q  <= '0;
          fill_q  <= '0;
          state_q <= FILL;
`endif
        end
      end
      // clr beats a coincident hit; the pulse itself is still issued above
      if (clr) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (hit_c && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_d;
        if (cnt_d == CNT_MAX) sat_q <= 1'b1;
      end
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign sat       = sat_q;
  assign hist      = hist_q;
  assign armed     = (state_q == ARMED);

endmodule
